// File: rtl/radio_seq_pkg.sv
// Shared types and constants for the radio enable sequencer.
// Holds the FSM state encoding, default cycle counts and counter sizing.
package radio_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WARMUP    = 2'd1,
    ACTIVE    = 2'd2,
    TURN_RAMP = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_WARMUP_CYCLES   = 4;
  localparam int unsigned DEF_TURN_CYCLES     = 2;
  localparam int unsigned DEF_RAMPDOWN_CYCLES = 3;

  // Bits needed to hold the largest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return unsigned'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/rs_downcounter.sv
// Loadable down-counter that saturates at zero; times the sequencer phases.
module rs_downcounter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge ck) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/radio_en_sequencer.sv
// Second sync stage plus warm-up / active / turnaround / ramp-down sequencer
// producing registered radio front-end enables and timing-engine status.
module radio_en_sequencer
  import radio_seq_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
  parameter int unsigned TURN_CYCLES     = DEF_TURN_CYCLES,
  parameter int unsigned RAMPDOWN_CYCLES = DEF_RAMPDOWN_CYCLES,
  parameter int unsigned CNT_W = cnt_width(WARMUP_CYCLES, TURN_CYCLES, RAMPDOWN_CYCLES)
) (
  input  logic       ck,
  input  logic       arst,
  input  logic       radioEnable1,
  input  logic       radioRxEn1,
  output logic       radioOn,
  output logic       rxActive,
  output logic       txActive,
  output logic       warmupDone,
  output logic [1:0] seqState
);

  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LOAD = CNT_W'(RAMPDOWN_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic             ramp_q, ramp_d;
  logic             mode_q, mode_d;
  logic             en2_q, rx2_q;
  logic             on_q, on_d;
  logic             rx_q, rx_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  rs_downcounter #(.CNT_W(CNT_W)) u_cnt (
    .ck         (ck),
    .arst       (arst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_c_o   (cnt_zero)
  );

  // Second synchroniser stage and FSM/output registers.
  always_ff @(posedge ck) begin
    if (arst) begin
      en2_q   <= 1'b0;
      rx2_q   <= 1'b0;
      state_q <= IDLE;
      ramp_q  <= 1'b0;
      mode_q  <= 1'b0;
      on_q    <= 1'b0;
      rx_q    <= 1'b0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en2_q   <= radioEnable1;
      rx2_q   <= radioRxEn1;
      state_q <= state_d;
      ramp_q  <= ramp_d;
      mode_q  <= mode_d;
      on_q    <= on_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state.
  always_comb begin
    state_d  = state_q;
    ramp_d   = ramp_q;
    mode_d   = mode_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en2_q) begin
          state_d  = WARMUP;
          cnt_load = 1'b1;
          cnt_val  = WARM_LOAD;
          mode_d   = rx2_q;
        end
      end
      WARMUP: begin
        if (!en2_q) begin
          state_d  = TURN_RAMP;
          ramp_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = RAMP_LOAD;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
          mode_d  = rx2_q;
        end else begin
          state_d = ACTIVE;
          mode_d  = rx2_q;
          done_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (!en2_q) begin
          state_d  = TURN_RAMP;
          ramp_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = RAMP_LOAD;
        end else if (rx2_q != mode_q) begin
          state_d  = TURN_RAMP;
          ramp_d   = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = TURN_LOAD;
        end
      end
      TURN_RAMP: begin
        if (ramp_q) begin
          // Ramp-down always runs to completion; enable is ignored here.
          if (cnt_zero) begin
            state_d = IDLE;
            ramp_d  = 1'b0;
          end else begin
            cnt_dec = 1'b1;
          end
        end else if (!en2_q) begin
          ramp_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = RAMP_LOAD;
        end else if (cnt_zero) begin
          state_d = ACTIVE;
          mode_d  = rx2_q;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    on_d = (state_d != IDLE);
    rx_d = (state_d == ACTIVE) && mode_d;
    tx_d = (state_d == ACTIVE) && !mode_d;
  end

  assign radioOn    = on_q;
  assign rxActive   = rx_q;
  assign txActive   = tx_q;
  assign warmupDone = done_q;
  assign seqState   = state_q;

  a_enables_exclusive: assert property (@(posedge ck) !(rx_q && tx_q));

endmodule

// File: tb/tb_radio_en_sequencer.sv
// Vector-table bench for radio_en_sequencer: each row drives one clock edge
// and the expected outputs after that edge go through a scoreboard queue.
module tb_radio_en_sequencer;

  logic       ck = 1'b0;
  logic       arst = 1'b1;
  logic       radioEnable1 = 1'b0;
  logic       radioRxEn1 = 1'b0;
  logic       radioOn, rxActive, txActive, warmupDone;
  logic [1:0] seqState;

  radio_en_sequencer dut (
    .ck           (ck),
    .arst         (arst),
    .radioEnable1 (radioEnable1),
    .radioRxEn1   (radioRxEn1),
    .radioOn      (radioOn),
    .rxActive     (rxActive),
    .txActive     (txActive),
    .warmupDone   (warmupDone),
    .seqState     (seqState)
  );

  always #5 ck = ~ck;

  // Expected output word: {radioOn, rxActive, txActive, warmupDone, seqState}
  localparam logic [5:0] E_IDLE = 6'b0000_00;
  localparam logic [5:0] E_WARM = 6'b1000_01;
  localparam logic [5:0] E_RD   = 6'b1000_11;
  localparam logic [5:0] E_TURN = 6'b1000_11;
  localparam logic [5:0] E_ARX  = 6'b1100_10;
  localparam logic [5:0] E_ATX  = 6'b1010_10;
  localparam logic [5:0] E_ARXP = 6'b1101_10;
  localparam logic [5:0] E_ATXP = 6'b1011_10;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       rx;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  task automatic add(input int n, input logic r, input logic e, input logic x,
                     input logic [5:0] ex);
    vec_t v;
    v.rst = r; v.en = e; v.rx = x; v.exp = ex;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    logic [5:0] got, want;

    // Reset state
    add(2, 1, 0, 0, E_IDLE);
    // RX warm-up (radioOn after 2nd edge, ACTIVE after 6th), then ramp-down
    add(1, 0, 1, 1, E_IDLE);
    add(4, 0, 1, 1, E_WARM);
    add(1, 0, 1, 1, E_ARXP);
    add(2, 0, 1, 1, E_ARX);
    add(1, 0, 0, 1, E_ARX);
    add(3, 0, 0, 1, E_RD);
    add(1, 0, 0, 1, E_IDLE);
    add(1, 0, 0, 0, E_IDLE);
    // TX warm-up, then TX->RX turnaround (2 dead cycles)
    add(1, 0, 1, 0, E_IDLE);
    add(4, 0, 1, 0, E_WARM);
    add(1, 0, 1, 0, E_ATXP);
    add(1, 0, 1, 0, E_ATX);
    add(1, 0, 1, 1, E_ATX);
    add(2, 0, 1, 1, E_TURN);
    add(1, 0, 1, 1, E_ARXP);
    add(1, 0, 1, 1, E_ARX);
    // RX select glitches low for one cycle: full turnaround still taken
    add(1, 0, 1, 0, E_ARX);
    add(2, 0, 1, 1, E_TURN);
    add(1, 0, 1, 1, E_ARXP);
    // Enable drop together with mode change: ramp-down wins
    add(1, 0, 0, 0, E_ARX);
    add(3, 0, 0, 0, E_RD);
    add(1, 0, 0, 0, E_IDLE);
    // 3-cycle enable pulse aborts warm-up
    add(1, 0, 1, 1, E_IDLE);
    add(2, 0, 1, 1, E_WARM);
    add(1, 0, 0, 1, E_WARM);
    add(3, 0, 0, 1, E_RD);
    add(1, 0, 0, 1, E_IDLE);
    // Enable held through ramp-down restarts the full warm-up
    add(1, 0, 1, 0, E_IDLE);
    add(4, 0, 1, 0, E_WARM);
    add(1, 0, 1, 0, E_ATXP);
    add(1, 0, 0, 0, E_ATX);
    add(3, 0, 1, 0, E_RD);
    add(1, 0, 1, 0, E_IDLE);
    add(4, 0, 1, 0, E_WARM);
    add(1, 0, 1, 0, E_ATXP);
    // Reset while ACTIVE
    add(1, 1, 1, 0, E_IDLE);
    add(1, 0, 1, 0, E_IDLE);
    add(4, 0, 1, 0, E_WARM);
    add(1, 0, 1, 0, E_ATXP);
    add(1, 0, 1, 1, E_ATX);
    add(1, 0, 1, 1, E_TURN);
    // Reset while in TURNAROUND
    add(1, 1, 1, 1, E_IDLE);
    add(2, 0, 0, 0, E_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge ck);
      arst         = vecs[i].rst;
      radioEnable1 = vecs[i].en;
      radioRxEn1   = vecs[i].rx;
      sb.push_back(vecs[i].exp);
      @(posedge ck);
      #1;
      got  = {radioOn, rxActive, txActive, warmupDone, seqState};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL row %0d {on,rx,tx,done,state}: got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                 i, got[5], got[4], got[3], got[2], got[1:0],
                 want[5], want[4], want[3], want[2], want[1:0]);
      end
      checks++;
      if (rxActive && txActive) begin
        errors++;
        $display("FAIL row %0d exclusive: rxActive=%b txActive=%b want not both 1",
                 i, rxActive, txActive);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
